// File: rtl/ram_tdp_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// The port tag records which RAM port carries a requester's pending read.
package ram_tdp_arb_pkg;

  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_0    = 2'd1,
    PORT_1    = 2'd2
  } port_tag_e;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

endpackage

// File: rtl/rr_find2.sv
// Finds the first and second set bits of vec, scanning in rotated order
// starting at index ptr and wrapping at NREQ.
module rr_find2 #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] vec,
  input  logic [IW-1:0]   ptr,
  output logic            found0,
  output logic [IW-1:0]   idx0,
  output logic            found1,
  output logic [IW-1:0]   idx1
);

  int pos;

  always_comb begin
    found0 = 1'b0;
    idx0   = '0;
    found1 = 1'b0;
    idx1   = '0;
    pos    = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (vec[pos]) begin
        if (!found0) begin
          found0 = 1'b1;
          idx0   = IW'(pos);
        end else if (!found1) begin
          found1 = 1'b1;
          idx1   = IW'(pos);
        end
      end
    end
  end

endmodule

// File: rtl/ram_tdp_arb.sv
// Round-robin arbiter mapping NREQ requesters onto an external true dual-port
// RAM with one-cycle read latency and same-address write-conflict deferral.
module ram_tdp_arb
  import ram_tdp_arb_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4,
  parameter int NREQ   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*AWIDTH-1:0]   req_addr,
  input  logic [NREQ*DWIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [NREQ*DWIDTH-1:0]   rsp_data,
  output logic                     cs_0,
  output logic                     oe_0,
  output logic                     we_0,
  output logic [AWIDTH-1:0]        addr_0,
  output logic [DWIDTH-1:0]        din_0,
  input  logic [DWIDTH-1:0]        dout_0,
  output logic                     cs_1,
  output logic                     oe_1,
  output logic                     we_1,
  output logic [AWIDTH-1:0]        addr_1,
  output logic [DWIDTH-1:0]        din_1,
  input  logic [DWIDTH-1:0]        dout_1,
  output logic [CNT_W-1:0]         conflict_cnt
);

  // Handshake: a request is accepted on a rising edge where req_valid[i] and
  // req_ready[i] are both high; req_ready is combinational and never waits on
  // anything but the current requests, the scan pointer and rst.

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]     ptr_q, ptr_d, idx0, idx1;
  logic              found0, found1;
  logic [AWIDTH-1:0] sel_addr0, sel_addr1;
  logic [DWIDTH-1:0] sel_wdata0, sel_wdata1;
  logic              sel_we0, sel_we1;
  logic              conflict, grant0, grant1;
  logic [CNT_W-1:0]  cnt_q;
  port_tag_e         tag_q [NREQ];

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    if (int'(i) == NREQ - 1) return '0;
    return i + IW'(1);
  endfunction

  rr_find2 #(.NREQ(NREQ), .IW(IW)) u_find (
    .vec    (req_valid),
    .ptr    (ptr_q),
    .found0 (found0),
    .idx0   (idx0),
    .found1 (found1),
    .idx1   (idx1)
  );

  always_comb begin
    sel_addr0  = req_addr[int'(idx0)*AWIDTH +: AWIDTH];
    sel_addr1  = req_addr[int'(idx1)*AWIDTH +: AWIDTH];
    sel_wdata0 = req_wdata[int'(idx0)*DWIDTH +: DWIDTH];
    sel_wdata1 = req_wdata[int'(idx1)*DWIDTH +: DWIDTH];
    sel_we0    = req_we[idx0];
    sel_we1    = req_we[idx1];
    // Two reads of one address may share a cycle; any write among them may not.
    conflict   = !rst && found0 && found1 && (sel_addr0 == sel_addr1) && (sel_we0 || sel_we1);
    grant0     = !rst && found0;
    grant1     = !rst && found1 && !conflict;
  end

  always_comb begin
    req_ready = '0;
    cs_0 = 1'b0; oe_0 = 1'b0; we_0 = 1'b0; addr_0 = '0; din_0 = '0;
    cs_1 = 1'b0; oe_1 = 1'b0; we_1 = 1'b0; addr_1 = '0; din_1 = '0;
    ptr_d = ptr_q;
    if (grant0) begin
      req_ready[idx0] = 1'b1;
      cs_0   = 1'b1;
      oe_0   = !sel_we0;
      we_0   = sel_we0;
      addr_0 = sel_addr0;
      din_0  = sel_we0 ? sel_wdata0 : '0;
      ptr_d  = wrap_inc(idx0);
    end
    if (grant1) begin
      req_ready[idx1] = 1'b1;
      cs_1   = 1'b1;
      oe_1   = !sel_we1;
      we_1   = sel_we1;
      addr_1 = sel_addr1;
      din_1  = sel_we1 ? sel_wdata1 : '0;
      ptr_d  = wrap_inc(idx1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < NREQ; i++) tag_q[i] <= PORT_NONE;
    end else begin
      ptr_q <= ptr_d;
      if (conflict && cnt_q != CNT_SAT) cnt_q <= cnt_q + CNT_W'(1);
      for (int i = 0; i < NREQ; i++) begin
        if (grant0 && !sel_we0 && idx0 == IW'(i))      tag_q[i] <= PORT_0;
        else if (grant1 && !sel_we1 && idx1 == IW'(i)) tag_q[i] <= PORT_1;
        else                                           tag_q[i] <= PORT_NONE;
      end
    end
  end

  // Read data returns straight from the RAM port recorded at grant time;
  // rst masks a response still in flight from the previous cycle.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!rst) begin
        case (tag_q[i])
          PORT_0: begin
            rsp_valid[i] = 1'b1;
            rsp_data[i*DWIDTH +: DWIDTH] = dout_0;
          end
          PORT_1: begin
            rsp_valid[i] = 1'b1;
            rsp_data[i*DWIDTH +: DWIDTH] = dout_1;
          end
          default: ;
        endcase
      end
    end
  end

  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_ram_tdp_arb.sv
// Directed bench for ram_tdp_arb: behavioural RAM, a request-list model checked
// every cycle, and hand-computed expectations for the key scenarios.
module tb_ram_tdp_arb;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_we, req_ready, rsp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata, rsp_data;
  logic              cs_0, oe_0, we_0, cs_1, oe_1, we_1;
  logic [AW-1:0]     addr_0, addr_1;
  logic [DW-1:0]     din_0, din_1;
  logic [DW-1:0]     dout_0 = '0;
  logic [DW-1:0]     dout_1 = '0;
  logic [15:0]       conflict_cnt;

  bit            v [NR];
  bit            w [NR];
  logic [AW-1:0] a [NR];
  logic [DW-1:0] d [NR];

  logic [DW-1:0] ram_mem  [2**AW];
  logic [DW-1:0] mdl_mem  [2**AW];
  bit            exp_rv   [NR];
  logic [DW-1:0] exp_rd   [NR];
  int            mdl_ptr = 0;
  int            mdl_cnt = 0;

  int tests = 0;
  int fails = 0;

  ram_tdp_arb #(.DWIDTH(DW), .AWIDTH(AW), .NREQ(NR)) dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_we (req_we), .req_addr (req_addr), .req_wdata (req_wdata),
    .req_ready (req_ready), .rsp_valid (rsp_valid), .rsp_data (rsp_data),
    .cs_0 (cs_0), .oe_0 (oe_0), .we_0 (we_0), .addr_0 (addr_0), .din_0 (din_0), .dout_0 (dout_0),
    .cs_1 (cs_1), .oe_1 (oe_1), .we_1 (we_1), .addr_1 (addr_1), .din_1 (din_1), .dout_1 (dout_1),
    .conflict_cnt (conflict_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_valid[i]            = v[i];
      req_we[i]               = w[i];
      req_addr[i*AW +: AW]    = a[i];
      req_wdata[i*DW +: DW]   = d[i];
    end
  end

  // External synchronous RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (cs_0 && we_0) ram_mem[addr_0] <= din_0;
    if (cs_0 && oe_0) dout_0 <= ram_mem[addr_0];
    if (cs_1 && we_1) ram_mem[addr_1] <= din_1;
    if (cs_1 && oe_1) dout_1 <= ram_mem[addr_1];
  end

  // ---------------- model ----------------
  function automatic void decide(output int g0, output int g1, output bit conf);
    int sel[$];
    g0 = -1; g1 = -1; conf = 1'b0;
    for (int k = 0; k < NR; k++)
      if (v[(mdl_ptr + k) % NR]) sel.push_back((mdl_ptr + k) % NR);
    if (sel.size() > 0) g0 = sel[0];
    if (sel.size() > 1) begin
      if (a[sel[0]] == a[sel[1]] && (w[sel[0]] || w[sel[1]])) conf = 1'b1;
      else g1 = sel[1];
    end
  endfunction

  function automatic logic [14:0] port_exp(input int g);
    if (g < 0) return '0;
    return {1'b1, !w[g], w[g], a[g], (w[g] ? d[g] : 8'h00)};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int  g0, g1;
    bit  conf;
    if (rst) begin
      mdl_ptr = 0;
      mdl_cnt = 0;
      for (int i = 0; i < NR; i++) exp_rv[i] = 1'b0;
    end else begin
      decide(g0, g1, conf);
      for (int i = 0; i < NR; i++) exp_rv[i] = 1'b0;
      foreach (exp_rv[i]) begin
        if (i == g0 || i == g1) begin
          if (w[i]) mdl_mem[a[i]] = d[i];
          else begin
            exp_rv[i] = 1'b1;
            exp_rd[i] = mdl_mem[a[i]];
          end
        end
      end
      if (conf && mdl_cnt < 65535) mdl_cnt++;
      if (g1 >= 0)      mdl_ptr = (g1 + 1) % NR;
      else if (g0 >= 0) mdl_ptr = (g0 + 1) % NR;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    int            g0, g1;
    bit            conf;
    logic [NR-1:0] er;
    decide(g0, g1, conf);
    if (rst) begin g0 = -1; g1 = -1; end
    er = '0;
    if (g0 >= 0) er[g0] = 1'b1;
    if (g1 >= 0) er[g1] = 1'b1;
    cmp("req_ready", 32'(req_ready), 32'(er));
    cmp("port0", 32'({cs_0, oe_0, we_0, addr_0, din_0}), 32'(port_exp(g0)));
    cmp("port1", 32'({cs_1, oe_1, we_1, addr_1, din_1}), 32'(port_exp(g1)));
    for (int i = 0; i < NR; i++) begin
      cmp("rsp_valid", 32'(rsp_valid[i]), 32'(!rst && exp_rv[i]));
      cmp("rsp_data", 32'(rsp_data[i*DW +: DW]), (!rst && exp_rv[i]) ? 32'(exp_rd[i]) : 32'd0);
    end
    cmp("conflict_cnt", 32'(conflict_cnt), 32'(mdl_cnt));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NR; i++) begin
      v[i] = 1'b0; w[i] = 1'b0; a[i] = '0; d[i] = '0;
    end
  endtask

  task automatic set_req(input int i, input bit we, input int addr, input int data);
    v[i] = 1'b1; w[i] = we; a[i] = AW'(addr); d[i] = DW'(data);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    step();
    rst = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int found;
    rst = 1'b1;
    clear_all();
    for (int i = 0; i < 2**AW; i++) begin
      ram_mem[i] = '0;
      mdl_mem[i] = '0;
    end
    step();
    step();
    @(negedge clk);
    cmp("rst_ready", 32'(req_ready), 32'd0);
    cmp("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    cmp("rst_cnt", 32'(conflict_cnt), 32'd0);
    step();
    rst = 1'b0;

    // Write then read back through requester 0.
    set_req(0, 1'b1, 3, 8'hA5);
    @(negedge clk);
    cmp("wr_ready", 32'(req_ready), 32'b0001);
    cmp("wr_port0", 32'({cs_0, we_0, addr_0, din_0}), 32'({1'b1, 1'b1, 4'd3, 8'hA5}));
    step();
    set_req(0, 1'b0, 3, 0);
    @(negedge clk);
    cmp("rd_ready", 32'(req_ready), 32'b0001);
    step();
    clear_all();
    @(negedge clk);
    cmp("rd_rsp_valid", 32'(rsp_valid), 32'b0001);
    cmp("rd_rsp_data", 32'(rsp_data[7:0]), 32'hA5);
    step();

    // Four continuous readers from ptr=0.
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 8 + i, 0);
    @(negedge clk);
    cmp("rr_grant_a", 32'(req_ready), 32'b0011);
    step();
    @(negedge clk);
    cmp("rr_grant_b", 32'(req_ready), 32'b1100);
    cmp("rr_rsp_a", 32'(rsp_valid), 32'b0011);
    step();
    @(negedge clk);
    cmp("rr_grant_c", 32'(req_ready), 32'b0011);
    cmp("rr_rsp_b", 32'(rsp_valid), 32'b1100);
    step();
    clear_all();

    // Same-address write conflict.
    do_reset();
    set_req(1, 1'b1, 5, 8'h11);
    set_req(2, 1'b1, 5, 8'h22);
    @(negedge clk);
    cmp("conf_grant_a", 32'(req_ready), 32'b0010);
    cmp("conf_port1_idle", 32'({cs_1, oe_1, we_1}), 32'd0);
    step();
    v[1] = 1'b0;
    @(negedge clk);
    cmp("conf_cnt", 32'(conflict_cnt), 32'd1);
    cmp("conf_grant_b", 32'(req_ready), 32'b0100);
    step();
    clear_all();
    @(negedge clk);
    cmp("conf_mem5", 32'(ram_mem[5]), 32'h22);
    step();

    // Two reads of one address share a cycle.
    do_reset();
    set_req(2, 1'b1, 7, 8'h5A);
    step();
    clear_all();
    set_req(0, 1'b0, 7, 0);
    set_req(1, 1'b0, 7, 0);
    @(negedge clk);
    cmp("rr_same_grant", 32'(req_ready), 32'b0011);
    step();
    clear_all();
    @(negedge clk);
    cmp("rr_same_valid", 32'(rsp_valid), 32'b0011);
    cmp("rr_same_d0", 32'(rsp_data[7:0]), 32'h5A);
    cmp("rr_same_d1", 32'(rsp_data[15:8]), 32'h5A);
    step();

    // Read in flight when reset arrives.
    set_req(1, 1'b1, 5, 8'h33);
    set_req(2, 1'b1, 5, 8'h44);
    step();
    clear_all();
    set_req(0, 1'b0, 7, 0);
    @(negedge clk);
    cmp("pre_rst_cnt", 32'(conflict_cnt), 32'd1);
    cmp("pre_rst_ready", 32'(req_ready), 32'b0001);
    step();
    rst = 1'b1;
    clear_all();
    @(negedge clk);
    cmp("rst_kill_rsp", 32'(rsp_valid), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, i, 0);
    @(negedge clk);
    cmp("post_rst_cnt", 32'(conflict_cnt), 32'd0);
    cmp("post_rst_ptr", 32'(req_ready), 32'b0011);
    step();
    clear_all();

    // Starvation bound and counter saturation.
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 9, 8'h10 + i);
    set_req(3, 1'b0, 12, 0);
    found = -1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (req_ready[3] && found < 0) found = c;
      step();
    end
    cmp("starve_wait", 32'(found), 32'd2);
    set_req(3, 1'b1, 9, 8'h13);
    repeat (65540) step();
    @(negedge clk);
    cmp("cnt_sat", 32'(conflict_cnt), 32'hFFFF);
    step();
    clear_all();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
